mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_if.sv | 49 ++++
 rtl/mem_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Handshake bundle between the fetch/MEM requesters, the arbiter and the memory bus.
// The master modport is the arbiter side; slave is the requester/bus environment side.
interface mem_bus_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_done;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_we;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_cancel;
    logic        data_done;
    logic [31:0] data_rdata;

    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    logic        stall_if;
    logic        stall_mem;

    modport master (
        input  inst_req, inst_addr,
        output inst_done, inst_rdata,
        input  data_req, data_we, data_size, data_addr, data_wdata, data_cancel,
        output data_done, data_rdata,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output stall_if, stall_mem
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_done, inst_rdata,
        output data_req, data_we, data_size, data_addr, data_wdata, data_cancel,
        input  data_done, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / MEM) arbiter onto a single split-phase memory bus.
// Define MEM_ARB_FAIR_EN to force an inst grant after three back-to-back data grants.
module mem_bus_arbiter (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master mem_if
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state_q;
    logic        owner_q;
    logic        bus_req_q;
    logic        bus_wr_q;
    logic [1:0]  bus_size_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;
    logic        inst_done_q;
    logic        data_done_q;

    logic        data_eligible;
    logic        grant_data;
    logic        stall_mem;

    assign data_eligible = mem_if.data_req & ~mem_if.data_cancel;

`ifdef MEM_ARB_FAIR_EN
    logic [1:0] fair_q;
    logic [1:0] fair_d;

    assign grant_data = data_eligible & ~((fair_q == 2'd3) & mem_if.inst_req);

    // Only arbitration cycles where inst is waiting move the counter.
    always_comb begin
        fair_d = fair_q;
        if (state_q == IDLE && mem_if.inst_req) begin
            if (!grant_data) begin
                fair_d = 2'd0;
            end else if (fair_q != 2'd3) begin
                fair_d = fair_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fair_q <= 2'd0;
        end else begin
            fair_q <= fair_d;
        end
    end
`else
    assign grant_data = data_eligible;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_size_q   <= 2'd0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_data) begin
                        owner_q     <= 1'b1;
                        bus_addr_q  <= mem_if.data_addr;
                        bus_wr_q    <= mem_if.data_we;
                        bus_size_q  <= mem_if.data_size;
                        bus_wdata_q <= mem_if.data_wdata;
                        bus_req_q   <= 1'b1;
                        state_q     <= ADDR;
                    end else if (mem_if.inst_req) begin
                        owner_q     <= 1'b0;
                        bus_addr_q  <= mem_if.inst_addr;
                        bus_wr_q    <= 1'b0;
                        bus_size_q  <= 2'd2;
                        bus_wdata_q <= 32'd0;
                        bus_req_q   <= 1'b1;
                        state_q     <= ADDR;
                    end
                end
                ADDR: begin
                    // A kill only wins while the bus has not yet taken the address.
                    if (mem_if.bus_addr_ok) begin
                        bus_req_q <= 1'b0;
                        state_q   <= DATA;
                    end else if (owner_q && mem_if.data_cancel) begin
                        bus_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                DATA: begin
                    if (mem_if.bus_data_ok) begin
                        if (owner_q) begin
                            data_rdata_q <= mem_if.bus_rdata;
                        end else begin
                            inst_rdata_q <= mem_if.bus_rdata;
                        end
                        data_done_q <= owner_q;
                        inst_done_q <= ~owner_q;
                        state_q     <= RESP;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_mem = mem_if.data_req & ~data_done_q & ~mem_if.data_cancel;

    assign mem_if.inst_done  = inst_done_q;
    assign mem_if.inst_rdata = inst_rdata_q;
    assign mem_if.data_done  = data_done_q;
    assign mem_if.data_rdata = data_rdata_q;
    assign mem_if.bus_req    = bus_req_q;
    assign mem_if.bus_wr     = bus_wr_q;
    assign mem_if.bus_size   = bus_size_q;
    assign mem_if.bus_addr   = bus_addr_q;
    assign mem_if.bus_wdata  = bus_wdata_q;
    assign mem_if.stall_mem  = stall_mem;
    assign mem_if.stall_if   = (mem_if.inst_req & ~inst_done_q) | stall_mem;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed corner cases plus randomized rounds,
// with a behavioural bus responder and a monitor that checks grants and completions.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if ifc();
    mem_bus_arbiter dut (.clk(clk), .rst(rst), .mem_if(ifc.master));

    typedef struct packed {
        logic        owner;
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          auto_en = 1'b1;
    int          addr_pct = 100;
    int          data_pct = 100;
    int          fair_cnt = 0;
    logic [31:0] rmap [logic [31:0]];
    exp_t        bus_q[$];
    exp_t        done_q[$];
    logic [31:0] last_inst = 32'd0;
    logic [31:0] last_data = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " bus_req"},    32'(ifc.bus_req),   32'd0);
        chk({tag, " bus_wr"},     32'(ifc.bus_wr),    32'd0);
        chk({tag, " bus_size"},   32'(ifc.bus_size),  32'd0);
        chk({tag, " bus_addr"},   ifc.bus_addr,       32'd0);
        chk({tag, " bus_wdata"},  ifc.bus_wdata,      32'd0);
        chk({tag, " inst_done"},  32'(ifc.inst_done), 32'd0);
        chk({tag, " data_done"},  32'(ifc.data_done), 32'd0);
        chk({tag, " inst_rdata"}, ifc.inst_rdata,     32'd0);
        chk({tag, " data_rdata"}, ifc.data_rdata,     32'd0);
    endtask

    // Behavioural bus slave: accepts addresses and returns data after random waits.
    initial begin : responder
        bit          in_data;
        bit          req_s;
        logic [31:0] cur_addr;
        in_data  = 1'b0;
        cur_addr = 32'd0;
        forever begin
            @(negedge clk);
            req_s = ifc.bus_req;
            @(posedge clk);
            if (!rst) in_data = 1'b0;
            else if (in_data && ifc.bus_data_ok) in_data = 1'b0;
            else if (!in_data && req_s && ifc.bus_addr_ok) in_data = 1'b1;
            #1;
            if (auto_en) begin
                if (in_data) begin
                    ifc.bus_addr_ok = 1'b0;
                    ifc.bus_data_ok = ($urandom_range(1, 100) <= data_pct);
                    ifc.bus_rdata   = rmap.exists(cur_addr) ? rmap[cur_addr] : 32'd0;
                end else begin
                    ifc.bus_data_ok = 1'b0;
                    ifc.bus_addr_ok = ifc.bus_req && ($urandom_range(1, 100) <= addr_pct);
                    if (ifc.bus_addr_ok) cur_addr = ifc.bus_addr;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        chk("stall_mem", 32'(ifc.stall_mem),
            32'(ifc.data_req & ~ifc.data_done & ~ifc.data_cancel));
        chk("stall_if", 32'(ifc.stall_if),
            32'((ifc.inst_req & ~ifc.inst_done) | (ifc.data_req & ~ifc.data_done & ~ifc.data_cancel)));
        if (ifc.bus_req && ifc.bus_addr_ok) begin
            if (bus_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL bus_grant: got unexpected grant addr=%h required none", ifc.bus_addr);
            end else begin
                e = bus_q.pop_front();
                chk("bus_addr", ifc.bus_addr, e.addr);
                chk("bus_wr", 32'(ifc.bus_wr), 32'(e.we));
                chk("bus_size", 32'(ifc.bus_size), 32'(e.size));
                if (e.we) chk("bus_wdata", ifc.bus_wdata, e.wdata);
            end
        end
        if (ifc.inst_done && ifc.data_done) begin
            checks++; errors++;
            $display("FAIL both_done: got inst_done=1 data_done=1 required at most one");
        end else if (ifc.inst_done || ifc.data_done) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected: got done inst=%0d data=%0d required none",
                         ifc.inst_done, ifc.data_done);
            end else begin
                e = done_q.pop_front();
                chk("done_owner", 32'(ifc.data_done), 32'(e.owner));
                if (ifc.data_done) begin
                    chk("data_rdata", ifc.data_rdata, e.rdata);
                    chk("inst_rdata_hold", ifc.inst_rdata, last_inst);
                    last_data = e.rdata;
                end else begin
                    chk("inst_rdata", ifc.inst_rdata, e.rdata);
                    chk("data_rdata_hold", ifc.data_rdata, last_data);
                    last_inst = e.rdata;
                end
                $display("txn %s addr=%h we=%0d size=%0d rdata=%h cyc=%0d",
                         ifc.data_done ? "D" : "I", e.addr, e.we, e.size, e.rdata, cyc);
            end
        end
    end

    task automatic push(input exp_t e);
        bus_q.push_back(e);
        done_q.push_back(e);
    endtask

    // One arbitration round; each requester holds its request until its own done pulse.
    task automatic run_round(input bit di, input bit dd, input exp_t it, input exp_t dt,
                             input bit chk_lat);
        bit inst_first;
        bit got_i, got_d;
        int t0, lat_i, lat_d;
        inst_first = 1'b0;
        if (di) rmap[it.addr] = it.rdata;
        if (dd) rmap[dt.addr] = dt.rdata;
        if (di && dd) begin
`ifdef MEM_ARB_FAIR_EN
            inst_first = (fair_cnt == 3);
`endif
            if (inst_first) begin
                push(it); push(dt);
            end else begin
                push(dt); push(it);
            end
            fair_cnt = 0;
        end else if (di) begin
            push(it);
            fair_cnt = 0;
        end else if (dd) begin
            push(dt);
        end
        ifc.inst_req = di;  ifc.inst_addr = it.addr;
        ifc.data_req = dd;  ifc.data_we = dt.we;  ifc.data_size = dt.size;
        ifc.data_addr = dt.addr;  ifc.data_wdata = dt.wdata;
        t0 = cyc; got_i = !di; got_d = !dd; lat_i = 0; lat_d = 0;
        for (int k = 0; k < 400 && !(got_i && got_d); k++) begin
            @(negedge clk);
            if (ifc.inst_done && !got_i) begin got_i = 1'b1; lat_i = cyc - t0; end
            if (ifc.data_done && !got_d) begin got_d = 1'b1; lat_d = cyc - t0; end
            tick();
            if (got_i) ifc.inst_req = 1'b0;
            if (got_d) ifc.data_req = 1'b0;
        end
        checks++;
        if (!(got_i && got_d)) begin
            errors++;
            $display("FAIL round_timeout: got inst_done=%0d data_done=%0d required both", got_i, got_d);
            ifc.inst_req = 1'b0; ifc.data_req = 1'b0;
        end
        if (chk_lat) begin
            if (di && dd) begin
                chk("lat_first", 32'(inst_first ? lat_i : lat_d), 32'd3);
                chk("lat_second", 32'(inst_first ? lat_d : lat_i), 32'd7);
            end else begin
                chk("lat_single", 32'(di ? lat_i : lat_d), 32'd3);
            end
        end
    endtask

    // Both requesters held high across n grants; the model predicts the grant order.
    task automatic run_stream(input int n);
        exp_t it, dt;
        bit   pick_inst;
        int   seen;
        it = '{owner: 1'b0, addr: 32'hBFC0_0100, we: 1'b0, size: 2'd2, wdata: 32'd0, rdata: 32'h2402_0007};
        dt = '{owner: 1'b1, addr: 32'h8000_4000, we: 1'b0, size: 2'd2, wdata: 32'd0, rdata: 32'hCAFE_F00D};
        rmap[it.addr] = it.rdata;
        rmap[dt.addr] = dt.rdata;
        for (int k = 0; k < n; k++) begin
            pick_inst = 1'b0;
`ifdef MEM_ARB_FAIR_EN
            pick_inst = (fair_cnt == 3);
`endif
            if (pick_inst) begin
                push(it); fair_cnt = 0;
            end else begin
                push(dt); if (fair_cnt < 3) fair_cnt++;
            end
        end
        ifc.inst_req = 1'b1; ifc.inst_addr = it.addr;
        ifc.data_req = 1'b1; ifc.data_we = 1'b0; ifc.data_size = 2'd2;
        ifc.data_addr = dt.addr; ifc.data_wdata = 32'd0;
        seen = 0;
        for (int k = 0; k < n * 20 && seen < n; k++) begin
            @(negedge clk);
            if (ifc.inst_done || ifc.data_done) seen++;
            tick();
        end
        ifc.inst_req = 1'b0; ifc.data_req = 1'b0;
        chk("stream_grants", 32'(seen), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        bus_q.delete(); done_q.delete();
        last_inst = 32'd0; last_data = 32'd0; fair_cnt = 0;
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        exp_t        it, dt;
        logic [31:0] rnd;
        int          kind;
        int          dcount;
        ifc.inst_req = 0; ifc.inst_addr = 0;
        ifc.data_req = 0; ifc.data_we = 0; ifc.data_size = 0; ifc.data_addr = 0;
        ifc.data_wdata = 0; ifc.data_cancel = 0;
        ifc.bus_addr_ok = 0; ifc.bus_data_ok = 0; ifc.bus_rdata = 0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 1'b1;
        tick(); tick();

        // Single fetch with an immediately responding bus.
        it = '{owner: 1'b0, addr: 32'hBFC0_0000, we: 1'b0, size: 2'd2, wdata: 32'd0, rdata: 32'h3C1A_0000};
        dt = '{owner: 1'b1, addr: 32'h8000_0000, we: 1'b0, size: 2'd2, wdata: 32'd0, rdata: 32'd0};
        run_round(1'b1, 1'b0, it, dt, 1'b1);
        tick(); tick();

        // Simultaneous fetch and byte store: store goes to the bus first.
        it = '{owner: 1'b0, addr: 32'hBFC0_0004, we: 1'b0, size: 2'd2, wdata: 32'd0, rdata: 32'h2408_0001};
        dt = '{owner: 1'b1, addr: 32'h8000_1003, we: 1'b1, size: 2'd0, wdata: 32'hAB00_0000, rdata: 32'h1122_3344};
        run_round(1'b1, 1'b1, it, dt, 1'b1);
        tick(); tick();

        // Load killed while the bus stalls the address phase.
        auto_en = 1'b0; ifc.bus_addr_ok = 1'b0; ifc.bus_data_ok = 1'b0;
        ifc.data_req = 1'b1; ifc.data_we = 1'b0; ifc.data_size = 2'd2; ifc.data_addr = 32'h8000_2000;
        tick();
        @(negedge clk); chk("cancel_bus_req_c1", 32'(ifc.bus_req), 32'd1);
        tick();
        @(negedge clk); chk("cancel_bus_addr_c2", ifc.bus_addr, 32'h8000_2000);
        tick();
        ifc.data_cancel = 1'b1;
        @(negedge clk); chk("cancel_stall_mem", 32'(ifc.stall_mem), 32'd0);
        tick();
        @(negedge clk);
        chk("cancel_bus_req_idle", 32'(ifc.bus_req), 32'd0);
        chk("cancel_no_done", 32'(ifc.data_done), 32'd0);
        ifc.data_req = 1'b0; ifc.data_cancel = 1'b0;
        tick();
        @(negedge clk); chk("cancel_bus_req_after", 32'(ifc.bus_req), 32'd0);
        tick();

        // Kill arriving after address acceptance must not stop the load.
        dt = '{owner: 1'b1, addr: 32'h8000_3000, we: 1'b0, size: 2'd2, wdata: 32'd0, rdata: 32'h1357_9BDF};
        push(dt);
        ifc.data_req = 1'b1; ifc.data_addr = dt.addr;
        tick(); ifc.bus_addr_ok = 1'b1;
        tick(); ifc.bus_addr_ok = 1'b0; ifc.data_cancel = 1'b1;
        tick(); ifc.bus_data_ok = 1'b1; ifc.bus_rdata = dt.rdata;
        dcount = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ifc.data_done) dcount++;
            tick();
            ifc.bus_data_ok = 1'b0;
        end
        chk("late_cancel_done_count", 32'(dcount), 32'd1);
        chk("late_cancel_rdata", ifc.data_rdata, 32'h1357_9BDF);
        ifc.data_req = 1'b0; ifc.data_cancel = 1'b0;
        tick();

        // Reset in the data phase, then a stale data_ok after release.
        it = '{owner: 1'b0, addr: 32'hBFC0_0200, we: 1'b0, size: 2'd2, wdata: 32'd0, rdata: 32'd0};
        bus_q.push_back(it);
        ifc.inst_req = 1'b1; ifc.inst_addr = it.addr;
        tick(); ifc.bus_addr_ok = 1'b1;
        tick(); ifc.bus_addr_ok = 1'b0; rst = 1'b0;
        tick(); rst = 1'b1; ifc.inst_req = 1'b0; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk); check_zero("post_reset");
        tick(); ifc.bus_data_ok = 1'b0;
        tick();
        @(negedge clk); check_zero("stale_data_ok");
        last_inst = 32'd0; last_data = 32'd0; fair_cnt = 0;
        tick();
        auto_en = 1'b1;

        // Continuous contention from both ports.
        run_stream(8);
        tick(); tick(); tick();
        do_reset();

        // Randomized rounds with variable bus wait states.
        for (int r = 0; r < 40; r++) begin
            addr_pct = $urandom_range(30, 100);
            data_pct = $urandom_range(30, 100);
            kind = $urandom_range(0, 2);
            rnd = $urandom();
            it = '{owner: 1'b0, addr: {4'hB, rnd[27:2], 2'b00}, we: 1'b0, size: 2'd2,
                   wdata: 32'd0, rdata: $urandom()};
            rnd = $urandom();
            dt.owner = 1'b1;
            dt.we    = 1'($urandom_range(0, 1));
            dt.size  = 2'($urandom_range(0, 2));
            dt.addr  = {4'h8, rnd[27:0]};
            if (dt.size == 2'd1) dt.addr[0] = 1'b0;
            else if (dt.size == 2'd2) dt.addr[1:0] = 2'b00;
            dt.wdata = $urandom();
            dt.rdata = $urandom();
            run_round(kind != 1, kind != 0, it, dt, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end
        tick(); tick();
        chk("end_bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("end_done_q_empty", 32'(done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
